// File: rtl/pwm_duty_ramp_if.sv
// pwm_duty_ramp_if: target-duty valid/ready handshake between a duty source and the ramp
interface pwm_duty_ramp_if #(parameter int R = 8);
  logic [R:0] target_duty;
  logic       target_valid;
  logic       target_ready;
  modport master (output target_duty, target_valid, input target_ready);
  modport slave  (input target_duty, target_valid, output target_ready);
endinterface

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slews a registered PWM duty toward an accepted target in fixed steps at a programmable rate
module pwm_duty_ramp #(
  parameter int R          = 8,
  parameter int TIMER_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pwm_duty_ramp_if.slave        tgt_if,
  input  logic [R:0]            step,
  input  logic [TIMER_BITS-1:0] interval,
  input  logic                  hold,
  output logic [R:0]            duty,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;
  localparam logic [R:0] FULL = {1'b1, {R{1'b0}}};
  state_t                state, state_n;
  logic [R:0]            tgt, tgt_n, duty_n;
  logic [TIMER_BITS-1:0] cnt, cnt_n;
  logic                  done_n;
  logic [R:0]            sat, step_eff, dn_diff, up_next, dn_next, stepped;
  logic [R+1:0]          up_sum;
  logic                  tick;
  assign sat      = tgt_if.target_duty > FULL ? FULL : tgt_if.target_duty;
  assign step_eff = step == '0 ? {{R{1'b0}}, 1'b1} : step;
  assign up_sum   = {1'b0, duty} + {1'b0, step_eff};
  assign up_next  = up_sum > {1'b0, tgt} ? tgt : up_sum[R:0];
  assign dn_diff  = duty - step_eff;
  assign dn_next  = (duty < step_eff || dn_diff < tgt) ? tgt : dn_diff;
  assign stepped  = state == RAMP_UP ? up_next : dn_next;
  assign tick     = cnt == interval;
  assign tgt_if.target_ready = state == IDLE;
  assign busy     = state != IDLE;
  // Next-state, counter and duty update: accept in IDLE, step on each interval tick unless held
  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    cnt_n   = cnt;
    duty_n  = duty;
    done_n  = 1'b0;
    if (state == IDLE) begin
      if (tgt_if.target_valid) begin
        tgt_n   = sat;
        cnt_n   = '0;
        state_n = sat > duty ? RAMP_UP : sat < duty ? RAMP_DOWN : IDLE;
        done_n  = sat == duty;
      end
    end else if (!hold) begin
      cnt_n = tick ? '0 : cnt + 1'b1;
      if (tick) begin
        duty_n = stepped;
        if (stepped == tgt) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
    end
  end
  // State registers; reset abandons any ramp and forces duty to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      tgt   <= '0;
      cnt   <= '0;
      duty  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      tgt   <= tgt_n;
      cnt   <= cnt_n;
      duty  <= duty_n;
      done  <= done_n;
    end
  end
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb_pwm_duty_ramp: directed self-checking bench for pwm_duty_ramp
module tb_pwm_duty_ramp;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [8:0]  step = '0;
  logic [15:0] interval = '0;
  logic        hold = 1'b0;
  logic [8:0]  duty;
  logic        busy, done;
  int          tests = 0;
  int          fails = 0;

  pwm_duty_ramp_if #(.R(8)) tif ();

  pwm_duty_ramp #(.R(8), .TIMER_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n), .tgt_if(tif), .step(step), .interval(interval),
    .hold(hold), .duty(duty), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Present a target and return #1 after the accept edge
  task automatic send(input logic [8:0] t);
    int n = 0;
    while (!tif.target_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (!tif.target_ready) begin
      fails++;
      $display("FAIL send_timeout: ready=%0b want 1", tif.target_ready);
    end
    tif.target_duty  = t;
    tif.target_valid = 1'b1;
    @(posedge clk); #1;
    tif.target_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({duty, busy, tif.target_ready, done} !== {9'd0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: duty=%0d busy=%0b ready=%0b done=%0b want 0 0 1 0", duty, busy, tif.target_ready, done);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_up_ramp();
    logic [8:0] exp = 9'd0;
    step = 9'd16;
    interval = 16'd3;
    send(9'd100);
    tests++;
    if (busy !== 1'b1 || tif.target_ready !== 1'b0 || duty !== 9'd0) begin
      fails++;
      $display("FAIL up_accept: busy=%0b ready=%0b duty=%0d want 1 0 0", busy, tif.target_ready, duty);
    end
    for (int k = 0; k < 7; k++) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        tests++;
        if (duty !== exp || done !== 1'b0) begin
          fails++;
          $display("FAIL up_between: duty=%0d done=%0b want %0d 0", duty, done, exp);
        end
      end
      exp = (k == 6) ? 9'd100 : exp + 9'd16;
      @(posedge clk); #1;
      tests++;
      if (duty !== exp || done !== (k == 6)) begin
        fails++;
        $display("FAIL up_step%0d: duty=%0d done=%0b want %0d %0b", k, duty, done, exp, k == 6);
      end
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || duty !== 9'd100) begin
      fails++;
      $display("FAIL up_end: done=%0b busy=%0b duty=%0d want 0 0 100", done, busy, duty);
    end
  endtask

  task automatic test_down_clamp();
    logic [8:0] exp [3] = '{9'd60, 9'd20, 9'd5};
    step = 9'd40;
    interval = 16'd0;
    send(9'd5);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      tests++;
      if (duty !== exp[k] || done !== (k == 2)) begin
        fails++;
        $display("FAIL down_step%0d: duty=%0d done=%0b want %0d %0b", k, duty, done, exp[k], k == 2);
      end
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || duty !== 9'd5) begin
      fails++;
      $display("FAIL down_end: done=%0b busy=%0b duty=%0d want 0 0 5", done, busy, duty);
    end
  endtask

  task automatic test_saturation();
    int bad = 0;
    int dones = 0;
    step = 9'd0;
    interval = 16'd0;
    send(9'd300);
    for (int k = 1; k <= 251; k++) begin
      @(posedge clk); #1;
      if (duty !== 9'(5 + k)) bad++;
      if (done === 1'b1) dones++;
    end
    tests++;
    if (bad != 0 || duty !== 9'd256) begin
      fails++;
      $display("FAIL sat_ramp: %0d bad steps, final duty=%0d want 0 bad, 256", bad, duty);
    end
    tests++;
    if (dones != 1 || done !== 1'b1) begin
      fails++;
      $display("FAIL sat_done: pulses=%0d last=%0b want 1 1", dones, done);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (duty !== 9'd256 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL sat_hold: duty=%0d busy=%0b done=%0b want 256 0 0", duty, busy, done);
    end
  endtask

  task automatic test_equal_target();
    step = 9'd206;
    interval = 16'd0;
    send(9'd50);
    @(posedge clk); #1;
    tests++;
    if (duty !== 9'd50 || done !== 1'b1) begin
      fails++;
      $display("FAIL eq_setup: duty=%0d done=%0b want 50 1", duty, done);
    end
    @(posedge clk); #1;
    send(9'd50);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || duty !== 9'd50) begin
      fails++;
      $display("FAIL eq_done: done=%0b busy=%0b duty=%0d want 1 0 50", done, busy, duty);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || tif.target_ready !== 1'b1) begin
      fails++;
      $display("FAIL eq_pulse: done=%0b ready=%0b want 0 1", done, tif.target_ready);
    end
  endtask

  task automatic test_hold_ignore();
    int n = 0;
    step = 9'd10;
    interval = 16'd3;
    send(9'd120);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      tests++;
      if (duty !== (c < 4 ? 9'd50 : 9'd60)) begin
        fails++;
        $display("FAIL hold_pre%0d: duty=%0d want %0d", c, duty, c < 4 ? 50 : 60);
      end
    end
    hold = 1'b1;
    tif.target_duty  = 9'd0;
    tif.target_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      tests++;
      if (duty !== 9'd60 || tif.target_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL hold_frozen%0d: duty=%0d ready=%0b busy=%0b want 60 0 1", c, duty, tif.target_ready, busy);
      end
    end
    hold = 1'b0;
    tif.target_valid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (duty !== 9'd60) begin
      fails++;
      $display("FAIL hold_phase_a: duty=%0d want 60", duty);
    end
    @(posedge clk); #1;
    tests++;
    if (duty !== 9'd70) begin
      fails++;
      $display("FAIL hold_phase_b: duty=%0d want 70", duty);
    end
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n != 20 || duty !== 9'd120) begin
      fails++;
      $display("FAIL hold_finish: cycles=%0d duty=%0d want 20 120", n, duty);
    end
  endtask

  task automatic test_reset_midramp();
    step = 9'd1;
    interval = 16'd0;
    @(posedge clk); #1;
    send(9'd200);
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (duty !== 9'd125 || busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_pre: duty=%0d busy=%0b want 125 1", duty, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({duty, busy, tif.target_ready, done} !== {9'd0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset: duty=%0d busy=%0b ready=%0b done=%0b want 0 0 1 0", duty, busy, tif.target_ready, done);
    end
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0 || duty !== 9'd0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL mid_after%0d: done=%0b duty=%0d busy=%0b want 0 0 0", c, done, duty, busy);
      end
    end
  endtask

  initial begin
    tif.target_duty  = '0;
    tif.target_valid = 1'b0;
    test_reset();
    test_up_ramp();
    test_down_clamp();
    test_saturation();
    test_equal_target();
    test_hold_ignore();
    test_reset_midramp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
